// File: rtl/lsu_mem_ctrl.sv
// Load/store responder between execute and the data-memory bus.
// Checks alignment, steers byte lanes, drives a single-beat bus handshake
// and returns sign/zero-extended load data.
// Optional feature macro: LSU_TIMEOUT_EN (abort a BUS wait after TIMEOUT_CYC cycles).
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              cmem_rd,
    input  logic              cmem_wr,
    input  logic [5:0]        calu_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              resp_valid,
    output logic [63:0]       rdata,
    output logic              err_misalign,
    output logic              err_bus,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_be,
    output logic [63:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [63:0]       bus_rdata,
    input  logic              bus_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    state_t     state;
    logic [5:0] op_q;
    logic [2:0] off_q;

    logic       accept;
    logic       illegal;
    logic       misalign;
    logic [7:0] size_mask;
    logic [2:0] align_mask;
    logic [63:0] rd_shift;
    logic [63:0] load_ext;

    // Elaboration-time sanity check on the timeout limit.
    if (TIMEOUT_CYC == 0) begin : g_tmo_chk
        $error("lsu_mem_ctrl: TIMEOUT_CYC must be nonzero");
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Request decode: legality, access size mask and alignment mask.
    always_comb begin
        accept     = req_valid & req_ready & (cmem_rd | cmem_wr);
        illegal    = 1'b1;
        size_mask  = 8'h00;
        align_mask = 3'b000;
        if (cmem_wr) begin
            case (calu_op)
                6'd18:   begin illegal = 1'b0; size_mask = 8'h01; align_mask = 3'b000; end
                6'd19:   begin illegal = 1'b0; size_mask = 8'h03; align_mask = 3'b001; end
                6'd20:   begin illegal = 1'b0; size_mask = 8'h0F; align_mask = 3'b011; end
                6'd21:   begin illegal = 1'b0; size_mask = 8'hFF; align_mask = 3'b111; end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (calu_op)
                6'd1, 6'd5: begin illegal = 1'b0; size_mask = 8'h01; align_mask = 3'b000; end
                6'd2, 6'd6: begin illegal = 1'b0; size_mask = 8'h03; align_mask = 3'b001; end
                6'd3, 6'd7: begin illegal = 1'b0; size_mask = 8'h0F; align_mask = 3'b011; end
                6'd4:       begin illegal = 1'b0; size_mask = 8'hFF; align_mask = 3'b111; end
                default:    illegal = 1'b1;
            endcase
        end
        misalign = |(addr[2:0] & align_mask);
    end

    // Load lane extraction and sign/zero extension from the latched opcode.
    always_comb begin
        rd_shift = bus_rdata >> {off_q, 3'b000};
        load_ext = '0;
        case (op_q)
            6'd1:    load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
            6'd2:    load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            6'd3:    load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            6'd4:    load_ext = rd_shift;
            6'd5:    load_ext = {56'd0, rd_shift[7:0]};
            6'd6:    load_ext = {48'd0, rd_shift[15:0]};
            6'd7:    load_ext = {32'd0, rd_shift[31:0]};
            default: load_ext = '0;
        endcase
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            resp_valid   <= 1'b0;
            rdata        <= '0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
            op_q         <= '0;
            off_q        <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= calu_op;
                        off_q     <= addr[2:0];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (illegal) begin
                            state        <= ST_RESP;
                            resp_valid   <= 1'b1;
                            err_bus      <= 1'b1;
                            err_misalign <= 1'b0;
                            rdata        <= '0;
                        end else if (misalign) begin
                            state        <= ST_RESP;
                            resp_valid   <= 1'b1;
                            err_bus      <= 1'b0;
                            err_misalign <= 1'b1;
                            rdata        <= '0;
                        end else begin
                            state     <= ST_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= cmem_wr;
                            bus_addr  <= {addr[ADDR_W-1:3], 3'b000};
                            bus_be    <= size_mask << addr[2:0];
                            bus_wdata <= wdata << {addr[2:0], 3'b000};
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt   <= '0;
`endif
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        state        <= ST_RESP;
                        bus_req      <= 1'b0;
                        resp_valid   <= 1'b1;
                        err_misalign <= 1'b0;
                        err_bus      <= bus_err_i;
                        rdata        <= (bus_err_i | bus_we) ? 64'd0 : load_ext;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state        <= ST_RESP;
                        bus_req      <= 1'b0;
                        resp_valid   <= 1'b1;
                        err_misalign <= 1'b0;
                        err_bus      <= 1'b1;
                        rdata        <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    bus_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        cmem_rd;
    logic        cmem_wr;
    logic [5:0]  calu_op;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        resp_valid;
    logic [63:0] rdata;
    logic        err_misalign;
    logic        err_bus;
    logic        busy;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [7:0]  bus_be;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        bus_err_i;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .cmem_rd(cmem_rd), .cmem_wr(cmem_wr), .calu_op(calu_op),
        .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata),
        .err_misalign(err_misalign), .err_bus(err_bus), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err_i(bus_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge; returns in the cycle after accept.
    task automatic issue(input logic rd, input logic wr, input logic [5:0] op,
                         input logic [31:0] a, input logic [63:0] d);
        req_valid = 1'b1; cmem_rd = rd; cmem_wr = wr; calu_op = op; addr = a; wdata = d;
        step();
        req_valid = 1'b0; cmem_rd = 1'b0; cmem_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({req_ready, busy, bus_req, resp_valid, err_misalign, err_bus, bus_we} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {req_ready, busy, bus_req, resp_valid, err_misalign, err_bus, bus_we});
        end
        checks++;
        if ({rdata, bus_wdata, bus_addr, bus_be} !== 168'd0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h be=%h expected all 0",
                     rdata, bus_wdata, bus_addr, bus_be);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lb_lbu();
        issue(1'b1, 1'b0, 6'd1, 32'h1003, 64'd0);
        checks++;
        if ({bus_req, bus_we, busy, req_ready, bus_be, bus_addr} !== {4'b1010, 8'h08, 32'h1000}) begin
            errors++;
            $display("FAIL lb_bus: got req=%b we=%b busy=%b rdy=%b be=%h addr=%h expected 1 0 1 0 08 00001000",
                     bus_req, bus_we, busy, req_ready, bus_be, bus_addr);
        end
        bus_rdata = 64'h0000_0000_8000_0000; bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({resp_valid, err_misalign, err_bus, bus_req, rdata} !== {4'b1000, 64'hFFFF_FFFF_FFFF_FF80}) begin
            errors++;
            $display("FAIL lb_resp: got v=%b mis=%b be=%b req=%b rdata=%h expected 1 0 0 0 ffffffffffffff80",
                     resp_valid, err_misalign, err_bus, bus_req, rdata);
        end
        step();
        checks++;
        if ({resp_valid, req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL lb_idle: got v=%b rdy=%b busy=%b expected 0 1 0", resp_valid, req_ready, busy);
        end
        issue(1'b1, 1'b0, 6'd5, 32'h1003, 64'd0);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({resp_valid, rdata} !== {1'b1, 64'h80}) begin
            errors++;
            $display("FAIL lbu_resp: got v=%b rdata=%h expected 1 0000000000000080", resp_valid, rdata);
        end
        step();
    endtask

    task automatic test_lh_wait();
        logic stable;
        issue(1'b1, 1'b0, 6'd2, 32'h1006, 64'd0);
        bus_rdata = 64'h8001_0000_0000_0000;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if ({bus_req, bus_be, bus_addr} !== {1'b1, 8'hC0, 32'h1000} || resp_valid !== 1'b0)
                stable = 1'b0;
            step();
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL lh_hold: bus signals not held (be=%h addr=%h req=%b) expected c0 00001000 1",
                     bus_be, bus_addr, bus_req);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({resp_valid, rdata} !== {1'b1, 64'hFFFF_FFFF_FFFF_8001}) begin
            errors++;
            $display("FAIL lh_resp: got v=%b rdata=%h expected 1 ffffffffffff8001", resp_valid, rdata);
        end
        step();
    endtask

    task automatic test_sw();
        issue(1'b0, 1'b1, 6'd20, 32'h2004, 64'h1122_3344);
        checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata[63:32]} !== {2'b11, 8'hF0, 32'h2000, 32'h1122_3344}) begin
            errors++;
            $display("FAIL sw_bus: got req=%b we=%b be=%h addr=%h wd_hi=%h expected 1 1 f0 00002000 11223344",
                     bus_req, bus_we, bus_be, bus_addr, bus_wdata[63:32]);
        end
        bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF; bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({resp_valid, err_misalign, err_bus, rdata} !== {3'b100, 64'd0}) begin
            errors++;
            $display("FAIL sw_resp: got v=%b mis=%b be=%b rdata=%h expected 1 0 0 0", resp_valid,
                     err_misalign, err_bus, rdata);
        end
        step();
    endtask

    task automatic test_bus_err();
        issue(1'b1, 1'b0, 6'd3, 32'h0008, 64'd0);
        bus_rdata = 64'h1234_5678_9ABC_DEF0; bus_ack = 1'b1; bus_err_i = 1'b1;
        step();
        bus_ack = 1'b0; bus_err_i = 1'b0;
        checks++;
        if ({resp_valid, err_misalign, err_bus, rdata} !== {3'b101, 64'd0}) begin
            errors++;
            $display("FAIL bus_err: got v=%b mis=%b be=%b rdata=%h expected 1 0 1 0", resp_valid,
                     err_misalign, err_bus, rdata);
        end
        step();
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 6'd3, 32'h3002, 64'd0);
        checks++;
        if ({resp_valid, err_misalign, err_bus, bus_req, req_ready, rdata} !== {5'b11000, 64'd0}) begin
            errors++;
            $display("FAIL misalign: got v=%b mis=%b be=%b req=%b rdy=%b rdata=%h expected 1 1 0 0 0 0",
                     resp_valid, err_misalign, err_bus, bus_req, req_ready, rdata);
        end
        step();
        checks++;
        if ({resp_valid, req_ready, bus_req} !== 3'b010) begin
            errors++;
            $display("FAIL misalign_idle: got v=%b rdy=%b req=%b expected 0 1 0", resp_valid, req_ready, bus_req);
        end
    endtask

    task automatic test_illegal();
        issue(1'b1, 1'b0, 6'd20, 32'h0100, 64'd0);
        checks++;
        if ({resp_valid, err_misalign, err_bus, bus_req} !== 4'b1010) begin
            errors++;
            $display("FAIL illegal_load: got v=%b mis=%b be=%b req=%b expected 1 0 1 0",
                     resp_valid, err_misalign, err_bus, bus_req);
        end
        step();
        // Both strobes means store, so a load opcode is illegal.
        issue(1'b1, 1'b1, 6'd3, 32'h0100, 64'd0);
        checks++;
        if ({resp_valid, err_misalign, err_bus, bus_req} !== 4'b1010) begin
            errors++;
            $display("FAIL illegal_both: got v=%b mis=%b be=%b req=%b expected 1 0 1 0",
                     resp_valid, err_misalign, err_bus, bus_req);
        end
        step();
    endtask

    task automatic test_ack_idle();
        bus_ack = 1'b1;
        step(); step();
        bus_ack = 1'b0;
        checks++;
        if ({resp_valid, busy, bus_req, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL ack_idle: got v=%b busy=%b req=%b rdy=%b expected 0 0 0 1",
                     resp_valid, busy, bus_req, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        logic       data_ok;
        bus_rdata = 64'hFFFF_FFFF_0000_0000; bus_ack = 1'b1;
        req_valid = 1'b1; cmem_rd = 1'b1; cmem_wr = 1'b0; calu_op = 6'd7; addr = 32'h4; wdata = '0;
        data_ok = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            seen[5-i] = resp_valid;
            if (resp_valid === 1'b1 && rdata !== 64'h0000_0000_FFFF_FFFF) data_ok = 1'b0;
            if (i < 5) step();
        end
        req_valid = 1'b0; cmem_rd = 1'b0; bus_ack = 1'b0;
        checks++;
        if (seen !== 6'b010010) begin
            errors++;
            $display("FAIL b2b_pattern: got %b expected 010010", seen);
        end
        checks++;
        if (data_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_lwu: last rdata=%h expected 00000000ffffffff", rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        int n;
        logic got;
`ifdef LSU_TIMEOUT_EN
        issue(1'b1, 1'b0, 6'd4, 32'h0008, 64'd0);
        n = 0; got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1; n = k;
            end else begin
                step();
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL timeout_cycle: resp at cycle %0d after accept expected 5", n);
        end
        checks++;
        if ({err_bus, bus_req, rdata} !== {2'b10, 64'd0}) begin
            errors++;
            $display("FAIL timeout_resp: got be=%b req=%b rdata=%h expected 1 0 0", err_bus, bus_req, rdata);
        end
        step();
`else
        issue(1'b1, 1'b0, 6'd4, 32'h0008, 64'd0);
        n = 0; got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (busy !== 1'b1 || bus_req !== 1'b1) n++;
            if (resp_valid === 1'b1) got = 1'b1;
            step();
        end
        checks++;
        if (n != 0 || got !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: %0d cycles not busy, resp=%b expected 0 0", n, got);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
    endtask

    task automatic test_reset_abort();
        issue(1'b1, 1'b0, 6'd4, 32'h0010, 64'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, bus_req, resp_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b req=%b v=%b rdy=%b expected 0 0 0 1",
                     busy, bus_req, resp_valid, req_ready);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_late_ack: got v=%b busy=%b expected 0 0", resp_valid, busy);
        end
        step();
        issue(1'b0, 1'b1, 6'd21, 32'h0040, 64'hDEAD_BEEF_CAFE_F00D);
        checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {2'b11, 8'hFF, 32'h40, 64'hDEAD_BEEF_CAFE_F00D}) begin
            errors++;
            $display("FAIL sd_bus: got req=%b we=%b be=%h addr=%h wd=%h expected 1 1 ff 00000040 deadbeefcafef00d",
                     bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if ({resp_valid, err_misalign, err_bus, rdata} !== {3'b100, 64'd0}) begin
            errors++;
            $display("FAIL sd_resp: got v=%b mis=%b be=%b rdata=%h expected 1 0 0 0",
                     resp_valid, err_misalign, err_bus, rdata);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; cmem_rd = 1'b0; cmem_wr = 1'b0; calu_op = '0;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0; bus_err_i = 1'b0;
        #1;
        test_reset();
        test_lb_lbu();
        test_lh_wait();
        test_sw();
        test_bus_err();
        test_misalign();
        test_illegal();
        test_ack_idle();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
